// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared constants and types for the MMU operand feeder
package mmu_pkg;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 3;
    localparam int FEED_STEPS = 3;
    localparam int STEP_W     = 2;

    localparam logic [ADDR_W-1:0] A_BASE = 3'd0;
    localparam logic [ADDR_W-1:0] B_BASE = 3'd4;

    // Element addresses, row-major within each matrix
    localparam logic [ADDR_W-1:0] ADDR_A00 = A_BASE + 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_A01 = A_BASE + 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_A10 = A_BASE + 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_A11 = A_BASE + 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_B00 = B_BASE + 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_B01 = B_BASE + 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_B10 = B_BASE + 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_B11 = B_BASE + 3'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FEED = 1'b1
    } feed_state_e;

endpackage

// File: rtl/mat_regfile.sv
// rtl/mat_regfile.sv - 8-entry operand store with skew-ordered read taps
module mat_regfile
    import mmu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STEP_W-1:0] step,
    output logic [DATA_W-1:0] a0_tap,
    output logic [DATA_W-1:0] a1_tap,
    output logic [DATA_W-1:0] b0_tap,
    output logic [DATA_W-1:0] b1_tap
);

    logic [DATA_W-1:0] mem_q [8];
    logic [DATA_W-1:0] mem_d [8];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Row 1 of A and column 1 of B lag by one step to form the diagonal wavefront
    always_comb begin
        a0_tap = '0;
        a1_tap = '0;
        b0_tap = '0;
        b1_tap = '0;
        case (step)
            2'd0: begin
                a0_tap = mem_q[ADDR_A00];
                b0_tap = mem_q[ADDR_B00];
            end
            2'd1: begin
                a0_tap = mem_q[ADDR_A01];
                a1_tap = mem_q[ADDR_A10];
                b0_tap = mem_q[ADDR_B10];
                b1_tap = mem_q[ADDR_B01];
            end
            2'd2: begin
                a1_tap = mem_q[ADDR_A11];
                b1_tap = mem_q[ADDR_B11];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mmu_feeder.sv
// rtl/mmu_feeder.sv - operand capture and skewed feed sequencer for the 2x2 MMU
module mmu_feeder
    import mmu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              feed_en,
    output logic [DATA_W-1:0] a0_out,
    output logic [DATA_W-1:0] a1_out,
    output logic [DATA_W-1:0] b0_out,
    output logic [DATA_W-1:0] b1_out,
    output logic              clear_acc,
    output logic              feed_valid,
    output logic              feed_done,
    output logic              busy
);

    feed_state_e       state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DATA_W-1:0] a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
    logic              clear_q, clear_d, valid_q, valid_d, done_q, done_d;
    logic [DATA_W-1:0] a0_tap, a1_tap, b0_tap, b1_tap;
    logic              wr_en;

    // Operands are frozen while a feed is in flight
    assign wr_en = load_en && (state_q == ST_IDLE);

    mat_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_en),
        .waddr  (load_addr),
        .wdata  (load_data),
        .step   (step_d),
        .a0_tap (a0_tap),
        .a1_tap (a1_tap),
        .b0_tap (b0_tap),
        .b1_tap (b1_tap)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (feed_en && !load_en) begin
                    state_d = ST_FEED;
                    step_d  = '0;
                end
            end
            ST_FEED: begin
                if (step_q == STEP_W'(FEED_STEPS - 1)) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    // Output registers load the taps for the step being entered
    always_comb begin
        a0_d    = '0;
        a1_d    = '0;
        b0_d    = '0;
        b1_d    = '0;
        valid_d = 1'b0;
        clear_d = 1'b0;
        if (state_d == ST_FEED) begin
            a0_d    = a0_tap;
            a1_d    = a1_tap;
            b0_d    = b0_tap;
            b1_d    = b1_tap;
            valid_d = 1'b1;
            clear_d = (state_q == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            a0_q    <= '0;
            a1_q    <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            clear_q <= clear_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign a0_out     = a0_q;
    assign a1_out     = a1_q;
    assign b0_out     = b0_q;
    assign b1_out     = b1_q;
    assign clear_acc  = clear_q;
    assign feed_valid = valid_q;
    assign feed_done  = done_q;
    assign busy       = (state_q == ST_FEED);

endmodule

// File: tb/tb_mmu_feeder.sv
// tb/tb_mmu_feeder.sv - self-checking bench for mmu_feeder
module tb_mmu_feeder;

    logic       clk;
    logic       rst_n;
    logic       load_en;
    logic [2:0] load_addr;
    logic [7:0] load_data;
    logic       feed_en;
    logic [7:0] a0_out, a1_out, b0_out, b1_out;
    logic       clear_acc, feed_valid, feed_done, busy;

    mmu_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .feed_en    (feed_en),
        .a0_out     (a0_out),
        .a1_out     (a1_out),
        .b0_out     (b0_out),
        .b1_out     (b1_out),
        .clear_acc  (clear_acc),
        .feed_valid (feed_valid),
        .feed_done  (feed_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [35:0] dut_out;
    assign dut_out = {a0_out, a1_out, b0_out, b1_out, clear_acc, feed_valid, feed_done, busy};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: matrices as a flat array, feed progress as a cycle count since start
    logic [7:0] m_mem [8];
    int         m_phase;
    logic       m_done;

    typedef struct packed {
        logic        le;
        logic [2:0]  la;
        logic [7:0]  ld;
        logic        fe;
        logic [35:0] exp;
    } vec_t;

    vec_t vecs [21];

    function automatic logic [35:0] pk(input logic [7:0] a0, a1, b0, b1,
                                       input logic clr, v, d, b);
        return {a0, a1, b0, b1, clr, v, d, b};
    endfunction

    function automatic vec_t mk(input logic le, input logic [2:0] la, input logic [7:0] ld,
                                input logic fe, input logic [35:0] exp);
        vec_t r;
        r.le = le; r.la = la; r.ld = ld; r.fe = fe; r.exp = exp;
        return r;
    endfunction

    function automatic logic [7:0] mat_a(input int r, input int c);
        return m_mem[2*r + c];
    endfunction

    function automatic logic [7:0] mat_b(input int r, input int c);
        return m_mem[4 + 2*r + c];
    endfunction

    function automatic logic [35:0] model_out();
        logic [7:0] a0, a1, b0, b1;
        int t;
        a0 = 8'h00; a1 = 8'h00; b0 = 8'h00; b1 = 8'h00;
        t = m_phase - 1;
        if (m_phase > 0) begin
            if (t <= 1) begin
                a0 = mat_a(0, t);
                b0 = mat_b(t, 0);
            end
            if (t >= 1) begin
                a1 = mat_a(1, t - 1);
                b1 = mat_b(t - 1, 1);
            end
        end
        return pk(a0, a1, b0, b1, m_phase == 1, m_phase > 0, m_done, m_phase > 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
        m_phase = 0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge(input logic le, input logic [2:0] la, input logic [7:0] ld,
                              input logic fe);
        m_done = 1'b0;
        if (m_phase == 0) begin
            if (le) m_mem[la] = ld;
            else if (fe) m_phase = 1;
        end else if (m_phase == 3) begin
            m_phase = 0;
            m_done  = 1'b1;
        end else begin
            m_phase = m_phase + 1;
        end
    endtask

    task automatic step_cycle(input logic le, input logic [2:0] la, input logic [7:0] ld,
                              input logic fe);
        load_en = le; load_addr = la; load_data = ld; feed_en = fe;
        @(posedge clk);
        model_edge(le, la, ld, fe);
        #1;
    endtask

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int clr_n, val_n, done_n;

    initial begin
        // Nominal load, frozen operands, ignored feed_en, load-over-feed priority
        vecs[0]  = mk(1, 3'd0, 8'd1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(1, 3'd1, 8'd2, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[2]  = mk(1, 3'd2, 8'd3, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[3]  = mk(1, 3'd3, 8'd4, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[4]  = mk(1, 3'd4, 8'd5, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[5]  = mk(1, 3'd5, 8'd6, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[6]  = mk(1, 3'd6, 8'd7, 0, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[7]  = mk(1, 3'd7, 8'd8, 1, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[8]  = mk(0, 3'd0, 8'd0, 1, pk(1, 0, 5, 0, 1, 1, 0, 1));
        vecs[9]  = mk(1, 3'd0, 8'd9, 1, pk(2, 3, 7, 6, 0, 1, 0, 1));
        vecs[10] = mk(0, 3'd0, 8'd0, 1, pk(0, 4, 0, 8, 0, 1, 0, 1));
        vecs[11] = mk(0, 3'd0, 8'd0, 1, pk(0, 0, 0, 0, 0, 0, 1, 0));
        vecs[12] = mk(0, 3'd0, 8'd0, 1, pk(1, 0, 5, 0, 1, 1, 0, 1));
        vecs[13] = mk(0, 3'd0, 8'd0, 0, pk(2, 3, 7, 6, 0, 1, 0, 1));
        vecs[14] = mk(0, 3'd0, 8'd0, 0, pk(0, 4, 0, 8, 0, 1, 0, 1));
        vecs[15] = mk(0, 3'd0, 8'd0, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));
        vecs[16] = mk(1, 3'd4, 8'hFD, 1, pk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs[17] = mk(0, 3'd0, 8'd0, 1, pk(1, 0, 8'hFD, 0, 1, 1, 0, 1));
        vecs[18] = mk(0, 3'd0, 8'd0, 0, pk(2, 3, 7, 6, 0, 1, 0, 1));
        vecs[19] = mk(0, 3'd0, 8'd0, 0, pk(0, 4, 0, 8, 0, 1, 0, 1));
        vecs[20] = mk(0, 3'd0, 8'd0, 0, pk(0, 0, 0, 0, 0, 0, 1, 0));

        rst_n = 1'b0; load_en = 1'b0; load_addr = 3'd0; load_data = 8'd0; feed_en = 1'b0;
        model_reset();
        #12;
        check("reset_state", dut_out, 36'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step_cycle(vecs[i].le, vecs[i].la, vecs[i].ld, vecs[i].fe);
            check($sformatf("vec%0d", i), dut_out, vecs[i].exp);
        end

        // Held feed_en: three sequences of 3 valid + 1 done cycle
        clr_n = 0; val_n = 0; done_n = 0;
        for (int i = 0; i < 12; i++) begin
            step_cycle(0, 3'd0, 8'd0, 1);
            check($sformatf("held%0d", i), dut_out, model_out());
            clr_n  += int'(clear_acc);
            val_n  += int'(feed_valid);
            done_n += int'(feed_done);
        end
        check("held_clear_count", 36'(clr_n), 36'd3);
        check("held_valid_count", 36'(val_n), 36'd9);
        check("held_done_count", 36'(done_n), 36'd3);
        step_cycle(0, 3'd0, 8'd0, 0);
        check("held_idle", dut_out, pk(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset asserted mid-feed: immediate clear, no done, memory wiped
        step_cycle(0, 3'd0, 8'd0, 1);
        check("pre_reset_feed", dut_out, model_out());
        step_cycle(0, 3'd0, 8'd0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_out, 36'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_cycle(0, 3'd0, 8'd0, i == 0);
            check($sformatf("post_reset%0d", i), dut_out,
                  pk(0, 0, 0, 0, i == 0, i < 3, i == 3, i < 3));
        end

        for (int i = 0; i < 400; i++) begin
            step_cycle(($urandom % 4) == 0, 3'($urandom), 8'($urandom), ($urandom % 3) == 0);
            check($sformatf("rand%0d", i), dut_out, model_out());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
